regfile_wb_arbiter: RTL

Shares the register file's single write port among NUM_REQ writeback requesters (default 3: ALU, LSU, MDU) using fair round-robin arbitration with a valid/ready handshake. The granted write is registered and driven to the register file write port. The block also keeps a pending-write scoreboard so issue logic can stall on RAW hazards against multi-cycle units. It sits between the execute/memory units and the register file.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file writeback path: default widths,
// requester indices and the writeback request record.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 1 << DEF_ADDR_WIDTH;

    // Pointer/index width covers the largest supported requester count (8).
    localparam int MAX_REQ   = 8;
    localparam int PTR_WIDTH = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // The input is one-hot, so OR-ing the set bit positions yields its index.
    function automatic logic [PTR_WIDTH-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [PTR_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | PTR_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping modulo NUM_REQ) receives a one-hot grant.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] rotated;
    logic [NUM_REQ-1:0] first;

    // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
    always_comb begin
        rotated = NUM_REQ'({req, req} >> ptr);
        first   = rotated & (~rotated + ONE);
        grant   = NUM_REQ'(({first, first} << ptr) >> NUM_REQ);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback units with a
// round-robin arbiter, registers the winning write, and tracks pending writes.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = 3
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
    output logic [NUM_REQ-1:0]               o_req_ready,
    input  logic                             i_claim_valid,
    input  logic [ADDR_WIDTH-1:0]            i_claim_addr,
    output logic                             o_rf_we,
    output logic [ADDR_WIDTH-1:0]            o_rf_addr,
    output logic [DATA_WIDTH-1:0]            o_rf_data,
    output logic [(1<<ADDR_WIDTH)-1:0]       o_pending
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_REQ - 1);

    logic [PTR_WIDTH-1:0]  ptr;
    logic [PTR_WIDTH-1:0]  ptr_nxt;
    logic [PTR_WIDTH-1:0]  grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  xfer;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        o_req_ready = i_rst ? '0 : grant;
        xfer        = |o_req_ready;
        grant_idx   = onehot_to_idx(MAX_REQ'(grant));
    end

    // Grant is one-hot, so an AND-OR mux selects the winning payload.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_addr = sel_addr | ({ADDR_WIDTH{grant[k]}} & i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_data = sel_data | ({DATA_WIDTH{grant[k]}} & i_req_data[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        wr_en = xfer && (sel_addr != '0);
    end

    always_comb begin
        ptr_nxt = ptr;
        if (xfer) begin
            ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_WIDTH'(1);
        end
    end

    // Claim is applied after the clear so a same-address claim keeps the bit set.
    always_comb begin
        pending_nxt = pending;
        if (xfer) begin
            pending_nxt[sel_addr] = 1'b0;
        end
        if (i_claim_valid) begin
            pending_nxt[i_claim_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr       <= '0;
            pending   <= '0;
            o_rf_we   <= 1'b0;
            o_rf_addr <= '0;
            o_rf_data <= '0;
        end else begin
            ptr     <= ptr_nxt;
            pending <= pending_nxt;
            o_rf_we <= wr_en;
            if (wr_en) begin
                o_rf_addr <= sel_addr;
                o_rf_data <= sel_data;
            end
        end
    end

    assign o_pending = pending;

endmodule
